// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: opcode map, default sizes,
// and the unit-select encoding used to route the queue head.
package issue_ctrl_pkg;

  localparam int unsigned DEF_QDEPTH    = 4;
  localparam int unsigned DEF_PAYLOAD_W = 96;
  localparam int unsigned DEF_ROB_SIZE  = 16;
  localparam int unsigned DEF_ROB_WID   = $clog2(DEF_ROB_SIZE);

  localparam logic [6:0] OPCODE_L     = 7'b0000011;
  localparam logic [6:0] OPCODE_S     = 7'b0100011;
  localparam logic [6:0] OPCODE_CAL   = 7'b0110011;
  localparam logic [6:0] OPCODE_CALI  = 7'b0010011;
  localparam logic [6:0] OPCODE_B     = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    UNIT_NONE     = 2'd0,
    UNIT_RS       = 2'd1,
    UNIT_LSB      = 2'd2,
    UNIT_ROB_ONLY = 2'd3
  } unit_e;

  function automatic unit_e route_unit(input logic [6:0] opcode);
    unit_e u;
    case (opcode)
      OPCODE_L, OPCODE_S:                            u = UNIT_LSB;
      OPCODE_CAL, OPCODE_CALI, OPCODE_B, OPCODE_JALR: u = UNIT_RS;
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL:          u = UNIT_ROB_ONLY;
      default:                                       u = UNIT_NONE;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/issue_ctrl_fifo.sv
// Small synchronous FIFO with flush; head data is read combinationally.
module issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             full, push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: in-order queue from the decoder, routes the head to
// RS / LSB / ROB-only, allocates ROB positions in order, flushes on rollback.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned QDEPTH    = DEF_QDEPTH,
  parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int unsigned ROB_SIZE  = DEF_ROB_SIZE,
  localparam int unsigned ROB_WID  = $clog2(ROB_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [6:0]           dec_opcode,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  input  logic                 rob_full,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  output logic                 iss_rob,
  output logic                 iss_rs,
  output logic                 iss_lsb,
  output logic                 iss_rob_only,
  output logic [6:0]           iss_opcode,
  output logic [PAYLOAD_W-1:0] iss_payload,
  output logic [ROB_WID-1:0]   iss_rob_pos,
  output logic                 illegal,
  output logic [15:0]          stall_cnt
);

  localparam int unsigned EW = PAYLOAD_W + 7;
  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [EW-1:0] head;
  logic [CW-1:0] q_count;
  logic          q_empty;
  unit_e         head_unit;
  logic          enq, go, tgt_ok, do_issue, do_drop, do_stall;

  logic [ROB_WID-1:0]   tail_q, tail_d, pos_q, pos_d;
  logic [15:0]          stall_q, stall_d;
  logic                 ill_q, ill_d;
  logic                 rob_q, rob_d, rs_q, rs_d, lsb_q, lsb_d, ro_q, ro_d;
  logic [6:0]           op_q, op_d;
  logic [PAYLOAD_W-1:0] pl_q, pl_d;

  issue_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (enq),
    .pop_i   (do_issue | do_drop),
    .flush_i (rollback),
    .wdata_i ({dec_opcode, dec_payload}),
    .rdata_o (head),
    .count_o (q_count),
    .empty_o (q_empty)
  );

  assign dec_ready = (q_count < CW'(QDEPTH));
  assign enq       = dec_valid & dec_ready & rdy & ~rollback;
  assign head_unit = route_unit(head[EW-1 -: 7]);

  always_comb begin
    tgt_ok = 1'b0;
    case (head_unit)
      UNIT_RS:       tgt_ok = ~rs_full;
      UNIT_LSB:      tgt_ok = ~lsb_full;
      UNIT_ROB_ONLY: tgt_ok = 1'b1;
      default:       tgt_ok = 1'b0;
    endcase
    go       = rdy & ~rollback & ~q_empty;
    do_drop  = go & (head_unit == UNIT_NONE);
    do_issue = go & (head_unit != UNIT_NONE) & ~rob_full & tgt_ok;
    do_stall = go & ~do_drop & ~do_issue;
  end

  // Strobes default low every cycle; payload outputs only move on an issue.
  always_comb begin
    tail_d  = tail_q;
    stall_d = stall_q;
    ill_d   = ill_q | do_drop;
    pos_d   = pos_q;
    op_d    = op_q;
    pl_d    = pl_q;
    rob_d   = do_issue;
    rs_d    = do_issue & (head_unit == UNIT_RS);
    lsb_d   = do_issue & (head_unit == UNIT_LSB);
    ro_d    = do_issue & (head_unit == UNIT_ROB_ONLY);
    if (do_stall && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    if (rollback) begin
      tail_d = '0;
    end else if (do_issue) begin
      pos_d  = tail_q;
      op_d   = head[EW-1 -: 7];
      pl_d   = head[PAYLOAD_W-1:0];
      tail_d = tail_q + ROB_WID'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tail_q  <= '0;
      stall_q <= '0;
      ill_q   <= 1'b0;
      pos_q   <= '0;
      op_q    <= '0;
      pl_q    <= '0;
      rob_q   <= 1'b0;
      rs_q    <= 1'b0;
      lsb_q   <= 1'b0;
      ro_q    <= 1'b0;
    end else begin
      tail_q  <= tail_d;
      stall_q <= stall_d;
      ill_q   <= ill_d;
      pos_q   <= pos_d;
      op_q    <= op_d;
      pl_q    <= pl_d;
      rob_q   <= rob_d;
      rs_q    <= rs_d;
      lsb_q   <= lsb_d;
      ro_q    <= ro_d;
    end
  end

  assign iss_rob      = rob_q;
  assign iss_rs       = rs_q;
  assign iss_lsb      = lsb_q;
  assign iss_rob_only = ro_q;
  assign iss_opcode   = op_q;
  assign iss_payload  = pl_q;
  assign iss_rob_pos  = pos_q;
  assign illegal      = ill_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_issue_ctrl;

  localparam int QD = 4;
  localparam int PW = 96;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rdy = 1'b0;
  logic          rollback = 1'b0;
  logic          dec_valid = 1'b0;
  logic [6:0]    dec_opcode = '0;
  logic [PW-1:0] dec_payload = '0;
  logic          rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
  logic          dec_ready, iss_rob, iss_rs, iss_lsb, iss_rob_only, illegal;
  logic [6:0]    iss_opcode;
  logic [PW-1:0] iss_payload;
  logic [3:0]    iss_rob_pos;
  logic [15:0]   stall_cnt;

  issue_ctrl #(.QDEPTH(QD), .PAYLOAD_W(PW), .ROB_SIZE(16)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_payload(dec_payload),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .iss_rob(iss_rob), .iss_rs(iss_rs), .iss_lsb(iss_lsb),
    .iss_rob_only(iss_rob_only), .iss_opcode(iss_opcode),
    .iss_payload(iss_payload), .iss_rob_pos(iss_rob_pos),
    .illegal(illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int k);
    return {32'(k), 32'hC0DE_0000 ^ 32'(k), ~32'(k)};
  endfunction

  // 0 = dropped, 1 = RS, 2 = LSB, 3 = complete at issue
  function automatic int kind_of(input logic [6:0] op);
    if (op inside {7'h03, 7'h23}) return 2;
    if (op inside {7'h33, 7'h13, 7'h63, 7'h67}) return 1;
    if (op inside {7'h37, 7'h17, 7'h6F}) return 3;
    return 0;
  endfunction

  typedef struct packed {
    logic [6:0]    op;
    logic [PW-1:0] pl;
  } ent_t;

  ent_t          mq[$];
  bit            m_rob, m_rs, m_lsb, m_ro, m_ill;
  logic [6:0]    m_op;
  logic [PW-1:0] m_pl;
  int            m_pos, m_tail, m_stall;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      {m_rob, m_rs, m_lsb, m_ro, m_ill} = '0;
      m_op = '0; m_pl = '0; m_pos = 0; m_tail = 0; m_stall = 0;
    end else begin
      {m_rob, m_rs, m_lsb, m_ro} = '0;
      if (rollback) begin
        mq.delete();
        m_tail = 0;
      end else if (rdy) begin
        int n;
        bit take;
        n = mq.size();
        take = dec_valid && (n < QD);
        if (n > 0) begin
          int k;
          k = kind_of(mq[0].op);
          if (k == 0) begin
            void'(mq.pop_front());
            m_ill = 1;
          end else if (rob_full || (k == 1 && rs_full) || (k == 2 && lsb_full)) begin
            if (m_stall < 65535) m_stall++;
          end else begin
            ent_t e;
            e = mq.pop_front();
            m_rob = 1; m_rs = (k == 1); m_lsb = (k == 2); m_ro = (k == 3);
            m_op = e.op; m_pl = e.pl; m_pos = m_tail;
            m_tail = (m_tail + 1) % 16;
          end
        end
        if (take) mq.push_back('{op: dec_opcode, pl: dec_payload});
      end
    end
  end

  always @(negedge clk) begin
    chk("dec_ready", dec_ready, mq.size() < QD);
    chk("iss_rob", iss_rob, m_rob);
    chk("iss_rs", iss_rs, m_rs);
    chk("iss_lsb", iss_lsb, m_lsb);
    chk("iss_rob_only", iss_rob_only, m_ro);
    chk("iss_opcode", iss_opcode, m_op);
    chk("iss_payload", iss_payload, m_pl);
    chk("iss_rob_pos", iss_rob_pos, m_pos);
    chk("illegal", illegal, m_ill);
    chk("stall_cnt", stall_cnt, m_stall);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] op, input int k);
    dec_valid = 1'b1;
    dec_opcode = op;
    dec_payload = mk(k);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("async_rst_rob", iss_rob, 0);
    chk("async_rst_ready", dec_ready, 1);
    chk("async_rst_pos", iss_rob_pos, 0);
    dec_valid = 0; rollback = 0; rdy = 1;
    rob_full = 0; rs_full = 0; lsb_full = 0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    logic [6:0] ops[8];
    int k;
    rdy = 1;
    step(); step();
    chk("reset_ready", dec_ready, 1);
    chk("reset_rob", iss_rob, 0);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_pos", iss_rob_pos, 0);
    rst = 1;

    // 4 back-to-back ADDI
    for (int i = 0; i < 6; i++) begin
      if (i < 4) send(7'h13, i); else dec_valid = 0;
      step();
      if (i >= 1 && i <= 4) begin
        chk("t1_rs", iss_rs, 1);
        chk("t1_pos", iss_rob_pos, i - 1);
      end
    end
    chk("t1_idle", iss_rob, 0);
    chk("t1_stall", stall_cnt, 0);

    // LW blocked by lsb_full, then queue fill
    do_reset();
    send(7'h03, 10); lsb_full = 1; step();
    dec_valid = 0;
    repeat (5) step();
    chk("t2_stall", stall_cnt, 5);
    chk("t2_no_lsb", iss_lsb, 0);
    lsb_full = 0; step();
    chk("t2_lsb", iss_lsb, 1);
    chk("t2_pos", iss_rob_pos, 0);
    chk("t2_payload", iss_payload, mk(10));
    lsb_full = 1;
    for (int i = 0; i < 4; i++) begin
      send(7'h23, 20 + i); step();
      chk("t2_ready", dec_ready, i < 3);
    end
    send(7'h23, 30); step();
    chk("t2_full_hold", dec_ready, 0);
    dec_valid = 0; lsb_full = 0;
    repeat (5) step();

    // 17 LUI with ROB position wrap
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (i < 17) send(7'h37, 100 + i); else dec_valid = 0;
      step();
      if (i >= 1) begin
        chk("t3_rob_only", iss_rob_only, 1);
        chk("t3_rs", iss_rs, 0);
        chk("t3_pos", iss_rob_pos, (i - 1) % 16);
      end
    end

    // rollback of a full queue
    do_reset();
    rob_full = 1;
    for (int i = 0; i < 4; i++) begin
      send(7'h33, 200 + i); step();
    end
    chk("t4_full", dec_ready, 0);
    rob_full = 0; rollback = 1; send(7'h33, 250); step();
    rollback = 0;
    chk("t4_rb_rob", iss_rob, 0);
    chk("t4_rb_ready", dec_ready, 1);
    send(7'h33, 260); step();
    dec_valid = 0; step();
    chk("t4_rs", iss_rs, 1);
    chk("t4_pos", iss_rob_pos, 0);
    chk("t4_payload", iss_payload, mk(260));

    // illegal opcode between two ADDs
    do_reset();
    send(7'h33, 300); step();
    send(7'h7F, 301); step();
    chk("t5_pos0", iss_rob_pos, 0);
    chk("t5_rs0", iss_rs, 1);
    send(7'h33, 302); step();
    chk("t5_drop_rob", iss_rob, 0);
    chk("t5_illegal", illegal, 1);
    dec_valid = 0; step();
    chk("t5_rs1", iss_rs, 1);
    chk("t5_pos1", iss_rob_pos, 1);
    chk("t5_payload1", iss_payload, mk(302));
    rollback = 1; step();
    rollback = 0; step();
    chk("t5_ill_kept", illegal, 1);

    // rdy low for 3 cycles mid-stream
    do_reset();
    k = 0;
    for (int i = 0; i < 9; i++) begin
      rdy = !(i >= 2 && i <= 4);
      if (k < 6) send(7'h13, 400 + k); else dec_valid = 0;
      step();
      if (rdy && k < 6) k++;
      if (i >= 2 && i <= 4) begin
        chk("t6_hold_rob", iss_rob, 0);
        chk("t6_hold_pos", iss_rob_pos, 0);
      end
      if (i == 5) begin
        chk("t6_resume_rs", iss_rs, 1);
        chk("t6_resume_pos", iss_rob_pos, 1);
        chk("t6_resume_pl", iss_payload, mk(401));
      end
    end
    dec_valid = 0; rdy = 1;
    repeat (3) step();

    // mixed opcodes with intermittent back-pressure
    do_reset();
    ops[0] = 7'h63; ops[1] = 7'h23; ops[2] = 7'h67; ops[3] = 7'h17;
    ops[4] = 7'h6F; ops[5] = 7'h03; ops[6] = 7'h00; ops[7] = 7'h33;
    for (int i = 0; i < 8; i++) begin
      send(ops[i], 500 + i);
      rs_full  = (i % 3 == 1);
      lsb_full = (i == 4);
      rob_full = (i == 6);
      step();
    end
    dec_valid = 0; rs_full = 0; lsb_full = 0; rob_full = 0;
    repeat (10) step();
    chk("t7_illegal", illegal, 1);
    chk("t7_ready", dec_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
